// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the CPU byte bus into the RAM and the I/O window.
// The I/O window is any address with cpu_a[17:16] == 2'b11, and the register is
// picked by cpu_a[2:0].
// The bridge owns the UART TX FIFO, the RX pop strobe, the free-running cycle
// counter with its read snapshot, and the program-stop pulse.
// Read data for both targets reaches the CPU exactly one cycle after the request.
module mmio_bridge #(
  parameter int          TX_DEPTH_BIT = 4,            // log2 of TX FIFO entries
  parameter int          FULL_MARGIN  = 2,            // free entries left when back-pressure asserts
  parameter int          RAM_ADDR_BIT = 17,           // RAM address width
  parameter logic [31:0] CNT_INIT     = 32'h0000_0000 // counter value loaded at reset (0 in normal use)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [31:0]             cpu_a,
  input  logic [7:0]              cpu_dout,
  input  logic                    cpu_wr,
  output logic [7:0]              cpu_din,
  output logic                    io_buffer_full,
  output logic [RAM_ADDR_BIT-1:0] ram_a,
  output logic [7:0]              ram_dout,
  output logic                    ram_wr,
  input  logic [7:0]              ram_din,
  input  logic [7:0]              rx_data,
  input  logic                    rx_empty,
  output logic                    rx_pop,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    program_stop,
  output logic                    tx_overflow
);

  // Source of the byte returned on the cycle after a read.
  typedef enum logic { SEL_RAM = 1'b0, SEL_IO = 1'b1 } sel_e;

  // I/O register offsets, decoded from cpu_a[2:0].
  localparam logic [2:0] OFS_RX    = 3'd0;  // RX pop on read, TX push on write
  localparam logic [2:0] OFS_CNT   = 3'd4;  // counter low byte and snapshot on read, stop on write
  localparam logic [2:0] OFS_SNAP1 = 3'd5;  // snapshot[15:8]
  localparam logic [2:0] OFS_SNAP2 = 3'd6;  // snapshot[23:16]
  localparam logic [2:0] OFS_SNAP3 = 3'd7;  // snapshot[31:24]

  localparam int unsigned              DEPTH    = 1 << TX_DEPTH_BIT;
  localparam logic [TX_DEPTH_BIT:0]    DEPTH_C  = DEPTH[TX_DEPTH_BIT:0];
  localparam logic [TX_DEPTH_BIT:0]    MARGIN_C = FULL_MARGIN[TX_DEPTH_BIT:0];
  localparam logic [TX_DEPTH_BIT-1:0]  PTR_ONE  = 1;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic       w_is_io;
  logic       w_rd;
  logic       w_wr;
  logic       w_io_rd;
  logic       w_io_wr;
  logic [2:0] w_ofs;
  logic       w_snap_ld;
  logic       w_stop;
  logic       w_unused_addr;

  // An access is accepted only while rdy_in is high.
  // RAM sees the low address bits and the write data unconditionally.
  assign w_is_io   = (cpu_a[17:16] == 2'b11);
  assign w_rd      = rdy_in & ~cpu_wr;
  assign w_wr      = rdy_in &  cpu_wr;
  assign w_io_rd   = w_rd & w_is_io;
  assign w_io_wr   = w_wr & w_is_io;
  assign w_ofs     = cpu_a[2:0];
  assign w_snap_ld = w_io_rd & (w_ofs == OFS_CNT);
  assign w_stop    = w_io_wr & (w_ofs == OFS_CNT);

  assign ram_a    = cpu_a[RAM_ADDR_BIT-1:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = w_wr & ~w_is_io;

  // The RX head is consumed in the same cycle as the read that returns it.
  assign rx_pop = w_io_rd & (w_ofs == OFS_RX) & ~rx_empty;

  // The upper address bits take no part in the decode.
  assign w_unused_addr = ^cpu_a[31:18];

  // ---------------------------------------------------------------------------
  // Cycle counter and snapshot
  // ---------------------------------------------------------------------------
  logic [31:0] r_cnt;
  logic [31:0] r_snap;

  // Free-running counter: counts every clock regardless of rdy_in and wraps naturally.
  // A read of the low byte latches all 32 bits, so reads of the upper bytes stay consistent.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt  <= CNT_INIT;
      r_snap <= 32'h0000_0000;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_snap_ld) begin
        r_snap <= r_cnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // I/O read data and one-cycle read return path
  // ---------------------------------------------------------------------------
  logic [7:0] w_io_rdata;
  logic       r_rd_pend;
  sel_e       r_sel;
  logic [7:0] r_io;
  logic [7:0] r_din_hold;

  // Selects the I/O register addressed by the current request.
  // NOTE: the default assignment comes first, so every path drives w_io_rdata and no latch is inferred.
  always_comb begin
    w_io_rdata = 8'h00;
    unique case (w_ofs)
      OFS_RX:    w_io_rdata = rx_empty ? 8'h00 : rx_data;
      OFS_CNT:   w_io_rdata = r_cnt[7:0];
      OFS_SNAP1: w_io_rdata = r_snap[15:8];
      OFS_SNAP2: w_io_rdata = r_snap[23:16];
      OFS_SNAP3: w_io_rdata = r_snap[31:24];
      default:   w_io_rdata = 8'h00;
    endcase
  end

  // Captures the target and any I/O data of an accepted read.
  // r_din_hold keeps whatever was last shown, so cpu_din is stable between reads.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rd_pend  <= 1'b0;
      r_sel      <= SEL_RAM;
      r_io       <= 8'h00;
      r_din_hold <= 8'h00;
    end else begin
      r_rd_pend  <= w_rd;
      r_din_hold <= cpu_din;
      if (w_rd) begin
        r_sel <= w_is_io ? SEL_IO : SEL_RAM;
        r_io  <= w_io_rdata;
      end
    end
  end

  // Presents the response of last cycle's read, otherwise holds the last value.
  always_comb begin
    cpu_din = r_din_hold;
    if (r_rd_pend) begin
      cpu_din = (r_sel == SEL_IO) ? r_io : ram_din;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]              r_mem [DEPTH];
  logic [TX_DEPTH_BIT-1:0] r_head;
  logic [TX_DEPTH_BIT-1:0] r_tail;
  logic [TX_DEPTH_BIT:0]   r_count;
  logic                    r_buf_full;
  logic                    r_ovf;
  logic                    r_stop;

  logic                    w_push;
  logic [7:0]              w_push_data;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_push_ok;
  logic [TX_DEPTH_BIT:0]   w_count_nxt;
  logic [TX_DEPTH_BIT:0]   w_free_nxt;

  // A non-zero byte written to offset 0 is pushed and a zero byte there is dropped.
  // A stop write always pushes the 0x00 marker.
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push      = w_stop | (w_io_wr & (w_ofs == OFS_RX) & (cpu_dout != 8'h00));
  assign w_push_data = w_stop ? 8'h00 : cpu_dout;
  assign w_pop       = tx_valid & tx_ready;
  assign w_full      = (r_count == DEPTH_C);
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_count_nxt = r_count
                     + {{TX_DEPTH_BIT{1'b0}}, w_push_ok}
                     - {{TX_DEPTH_BIT{1'b0}}, w_pop};
  assign w_free_nxt  = DEPTH_C - w_count_nxt;

  // Writes the pushed byte into the FIFO storage.
  // NOTE: the FIFO storage has no reset; count and pointers define which entries are valid.
  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      r_mem[r_tail] <= w_push_data;
    end
  end

  // Updates pointers, occupancy, sticky overflow, back-pressure and the stop pulse.
  // io_buffer_full looks ahead to the next count, so it is registered in step with that count.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_buf_full <= 1'b0;
      r_ovf      <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_push_ok) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_push & ~w_push_ok) begin
        r_ovf <= 1'b1;
      end
      r_count    <= w_count_nxt;
      r_buf_full <= (w_free_nxt <= MARGIN_C);
      r_stop     <= w_stop;
    end
  end

  assign tx_valid       = (r_count != '0);
  assign tx_data        = tx_valid ? r_mem[r_head] : 8'h00;
  assign io_buffer_full = r_buf_full;
  assign tx_overflow    = r_ovf;
  assign program_stop   = r_stop;

endmodule
